// File: rtl/log_ram_reader.sv
// log_ram_reader
//   Dumps a block of words from the capture RAM as a byte stream over a
//   valid/ready interface (for example into a UART transmitter). A start pulse
//   launches a dump of i_num_words words beginning at i_start_adrs. Each word is
//   sent MSB byte first. The address wraps from RAM_DEPTH-1 to 0.
//
//   Optional feature (macro LOG_DUMP_CHECKSUM_EN): when defined, an 8-bit
//   modulo-256 sum of every accepted data byte is appended as one extra byte.
//   A zero-word dump then sends only the checksum byte 0x00. When the macro is
//   undefined there is no checksum state and no checksum logic.
//
// Ports
//   clk              system clock
//   i_reset          synchronous reset, active high
//   i_start          one-cycle start pulse, ignored while o_busy
//   i_start_adrs     first RAM address, sampled on an accepted i_start
//   i_num_words      number of words to dump (0 = no data), sampled on i_start
//   o_read_adrs      RAM read address
//   o_en_read        RAM read enable, exactly one cycle per word
//   i_data_for_read  RAM read data, valid one cycle after o_en_read
//   o_byte           output byte (registered)
//   o_byte_valid     o_byte is valid (registered)
//   i_byte_ready     downstream accepts the byte
//   o_busy           a dump is in progress
//   o_done           sticky end-of-dump flag, cleared by the next accepted start

module log_ram_reader #(
    parameter int unsigned RAM_WIDTH = 32,
    parameter int unsigned RAM_DEPTH = 32768,
    localparam int unsigned AW = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [AW-1:0]        i_start_adrs,
    input  logic [AW:0]          i_num_words,
    output logic [AW-1:0]        o_read_adrs,
    output logic                 o_en_read,
    input  logic [RAM_WIDTH-1:0] i_data_for_read,
    output logic [7:0]           o_byte,
    output logic                 o_byte_valid,
    input  logic                 i_byte_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned NBYTES = RAM_WIDTH / 8;
    localparam int unsigned IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0]  LAST_IDX  = IW'(NBYTES - 1);
    localparam logic [AW-1:0]  ADRS_LAST = AW'(RAM_DEPTH - 1);
    localparam logic [AW:0]    ONE_WORD  = (AW + 1)'(1);

`ifdef LOG_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StReq, StWait, StSend, StCsum} state_t;
`else
    typedef enum logic [1:0] {StIdle, StReq, StWait, StSend} state_t;
`endif

    state_t                 state;
    logic [AW:0]            words;      // words still to send, including the current one
    logic [RAM_WIDTH-1:0]   shift;      // current word, next byte to send at the top
    logic [IW-1:0]          byte_idx;   // bytes left in the word after the one on o_byte
    logic [RAM_WIDTH-1:0]   shift_next;
    logic [AW-1:0]          adrs_next;

    assign shift_next = shift << 8;
    // Explicit wrap so non power-of-two depths also roll over to address 0.
    assign adrs_next  = (o_read_adrs == ADRS_LAST) ? '0 : o_read_adrs + AW'(1);

`ifdef LOG_DUMP_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_next;

    // Running sum including the byte being accepted this cycle.
    assign csum_next = csum + o_byte;
`endif

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state        <= StIdle;
            words        <= '0;
            shift        <= '0;
            byte_idx     <= '0;
            o_read_adrs  <= '0;
            o_en_read    <= 1'b0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
`ifdef LOG_DUMP_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (i_start) begin
                        o_read_adrs <= i_start_adrs;
                        words       <= i_num_words;
                        o_done      <= 1'b0;
`ifdef LOG_DUMP_CHECKSUM_EN
                        csum        <= '0;
`endif
                        if (i_num_words != '0) begin
                            state     <= StReq;
                            o_en_read <= 1'b1;
                            o_busy    <= 1'b1;
                        end else begin
`ifdef LOG_DUMP_CHECKSUM_EN
                            // Empty dump still carries its (zero) checksum.
                            state        <= StCsum;
                            o_busy       <= 1'b1;
                            o_byte       <= 8'h00;
                            o_byte_valid <= 1'b1;
`else
                            // Nothing to send: finish without leaving IDLE.
                            o_done       <= 1'b1;
`endif
                        end
                    end
                end

                StReq: begin
                    // o_en_read was raised on entry so the RAM sees it this cycle.
                    o_en_read <= 1'b0;
                    state     <= StWait;
                end

                StWait: begin
                    shift        <= i_data_for_read;
                    o_byte       <= i_data_for_read[RAM_WIDTH-1 -: 8];
                    o_byte_valid <= 1'b1;
                    byte_idx     <= LAST_IDX;
                    state        <= StSend;
                end

                StSend: begin
                    // o_byte_valid is always high here, so ready alone is the handshake.
                    if (i_byte_ready) begin
`ifdef LOG_DUMP_CHECKSUM_EN
                        csum <= csum_next;
`endif
                        if (byte_idx != '0) begin
                            shift    <= shift_next;
                            o_byte   <= shift_next[RAM_WIDTH-1 -: 8];
                            byte_idx <= byte_idx - IW'(1);
                        end else begin
                            o_read_adrs <= adrs_next;
                            words       <= words - ONE_WORD;
                            if (words != ONE_WORD) begin
                                state        <= StReq;
                                o_en_read    <= 1'b1;
                                o_byte_valid <= 1'b0;
                            end else begin
`ifdef LOG_DUMP_CHECKSUM_EN
                                // Valid stays high; the sum replaces the last data byte.
                                state        <= StCsum;
                                o_byte       <= csum_next;
`else
                                state        <= StIdle;
                                o_byte_valid <= 1'b0;
                                o_busy       <= 1'b0;
                                o_done       <= 1'b1;
`endif
                            end
                        end
                    end
                end

`ifdef LOG_DUMP_CHECKSUM_EN
                StCsum: begin
                    if (i_byte_ready) begin
                        state        <= StIdle;
                        o_byte_valid <= 1'b0;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                    end
                end
`endif

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
